decrypt_single_round: RTL and testbench
=======================================

DECRYPT_SINGLE_ROUND -- requirements
Module: decrypt_single_round

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: block, state and key width in bits.
REQ-002 SHALL have clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have keyLen, input, 1: 1 selects prev_key as the round key, 0 selects key_in.
REQ-005 SHALL have round_valid_in, input, 1: state_in, keys, keyLen and last_round are valid.
REQ-006 SHALL have round_ready_out, output, 1: the block accepts input this cycle.
REQ-007 SHALL have last_round, input, 1: final inverse round; InvMixColumns is skipped.
REQ-008 SHALL have state_in, input, DATA_WIDTH: ciphertext state entering the inverse round.
REQ-009 SHALL have prev_key, input, DATA_WIDTH: round key used when keyLen=1.
REQ-010 SHALL have key_in, input, DATA_WIDTH: round key used when keyLen=0.
REQ-011 SHALL have state_out, output, DATA_WIDTH: state after one inverse round, registered.
REQ-012 SHALL have round_valid_out, output, 1: state_out is valid.
REQ-013 SHALL have round_ready_in, input, 1: the downstream stage accepts state_out.

Function
REQ-014 SHALL compute one FIPS-197 inverse-cipher round, in this order: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns (omitted when last_round=1).
REQ-015 SHALL accept an input when round_valid_in and round_ready_out are both high.
REQ-016 SHALL be a 2-stage pipeline.
- S1 registers InvSubBytes(InvShiftRows(state_in)), the key selected by keyLen, and last_round.
- S2 registers AddRoundKey and the conditional InvMixColumns result.
REQ-017 SHALL have a latency of exactly 2 clk cycles from acceptance to round_valid_out, absent backpressure.
REQ-018 SHALL capture the selected round key at acceptance; later changes to keyLen, prev_key or key_in do not affect in-flight data.
REQ-019 SHALL advance S2 when S2 is empty or round_ready_in=1.
REQ-020 SHALL advance S1 when S1 is empty or S2 advances.
REQ-021 SHALL drive round_ready_out = (S1 empty) OR (S1 advances); this is combinational and has no path from round_valid_in.
REQ-022 SHALL sustain a throughput of one block per cycle while round_ready_in=1.
REQ-023 SHALL, when round_valid_out=1 and round_ready_in=0, hold state_out and round_valid_out stable until the transfer completes; no data is dropped or duplicated.
REQ-024 SHALL, with both stages full and round_ready_in=0, deassert round_ready_out.
REQ-025 SHALL, when round_ready_in rises while both stages are full, transfer S2, shift S1 to S2 and accept a new input in the same cycle.
REQ-026 SHALL deliver blocks strictly in acceptance order.
REQ-027 SHALL implement InvMixColumns with GF(2^8) xtime chains reduced by 0x11b: coefficients 0e, 0b, 0d, 09 per column, column-major byte order with byte 0 at bits [127:120].

Reset
REQ-028 SHALL, while rst=0, clear both stage valid flags asynchronously and drive round_valid_out=0, state_out=0 and round_ready_out=0.
REQ-029 SHALL, if rst asserts mid-operation, discard all in-flight blocks; none appears after reset release.
REQ-030 SHALL drive round_ready_out=1 in the first cycle after reset release.

Structure
REQ-031 SHALL take the inverse S-box table, the InvMixColumns coefficients and DATA_WIDTH from a shared AES package also used by the encrypt path.
REQ-032 SHALL instantiate one sub-module, inv_sbox (8-bit in, 8-bit out, combinational), 16 times.

Verification
REQ-033 SHALL cover a FIPS-197 C.1 middle round.
- Stimulus: state_in=7ad5fda789ef4e272bca100b3d9ff59f, keyLen=0, key_in=549932d1f08557681093ed9cbe2c974e, last_round=0.
- Response: two cycles later, state_out=54d990a16ba09ab596bbf40ea111702f.
REQ-034 SHALL cover the last round.
- Stimulus: state_in=7a9f102789d5f50b2beffd9f3dca4ea7 with last_round=0 and an all-zero key, then 6353e08c0960e104cd70b751bacad0e7 with last_round=1, keyLen=1, prev_key=000102030405060708090a0b0c0d0e0f.
- Response: the second output is 00112233445566778899aabbccddeeff.
REQ-035 SHALL cover backpressure.
- Stimulus: 3 back-to-back valid blocks with round_ready_in=0.
- Response: round_ready_out falls after 2 accepts; after round_ready_in=1, all 3 emerge in order with values stable while stalled.
REQ-036 SHALL cover key capture: change key_in one cycle after acceptance; state_out still reflects the key captured at acceptance.
REQ-037 SHALL cover reset mid-operation: assert rst with both stages full; round_valid_out=0 immediately, no stale block after release, round_ready_out=1 the next cycle.

Source files
------------

// File: rtl/decrypt_single_round_pkg.sv
// Shared AES definitions: data width, inverse S-box table, InvMixColumns coefficients
// and the GF(2^8) helpers used by both the encrypt and decrypt round paths.
package decrypt_single_round_pkg;

    localparam int unsigned AES_DATA_WIDTH = 128;

    // Entry n lives at bits [2047-8n -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [7:0] INV_MC_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    typedef struct packed {
        logic [AES_DATA_WIDTH-1:0] data;
        logic [AES_DATA_WIDTH-1:0] key;
        logic                      last;
    } s1_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] coef);
        logic [7:0] acc;
        logic [7:0] term;
        acc  = '0;
        term = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (coef[i]) acc = acc ^ term;
            term = xtime(term);
        end
        return acc;
    endfunction

    function automatic logic [AES_DATA_WIDTH-1:0] inv_shift_rows(input logic [AES_DATA_WIDTH-1:0] s);
        logic [AES_DATA_WIDTH-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned row = 0; row < 4; row++)
                r[127-8*(4*c+row) -: 8] = s[127-8*(4*((c+4-row)%4)+row) -: 8];
        return r;
    endfunction

    function automatic logic [AES_DATA_WIDTH-1:0] inv_mix_columns(input logic [AES_DATA_WIDTH-1:0] s);
        logic [AES_DATA_WIDTH-1:0] r;
        logic [7:0] acc;
        r = '0;
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned row = 0; row < 4; row++) begin
                acc = '0;
                for (int unsigned i = 0; i < 4; i++)
                    acc = acc ^ gf_mul(s[127-8*(4*c+(row+i)%4) -: 8], INV_MC_COEF[i]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        return r;
    endfunction

endpackage

// File: rtl/decrypt_single_round_inv_sbox.sv
// Combinational AES inverse S-box lookup for one byte.
module inv_sbox
    import decrypt_single_round_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    assign result = INV_SBOX[2047 - 8*int'(value) -: 8];

endmodule

// File: rtl/decrypt_single_round.sv
// One AES inverse-cipher round as a 2-stage valid/ready pipeline:
// S1 holds InvSubBytes(InvShiftRows(state)) with its captured key, S2 holds the round result.
module decrypt_single_round
    import decrypt_single_round_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AES_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  keyLen,
    input  logic                  round_valid_in,
    output logic                  round_ready_out,
    input  logic                  last_round,
    input  logic [DATA_WIDTH-1:0] state_in,
    input  logic [DATA_WIDTH-1:0] prev_key,
    input  logic [DATA_WIDTH-1:0] key_in,
    output logic [DATA_WIDTH-1:0] state_out,
    output logic                  round_valid_out,
    input  logic                  round_ready_in
);

    logic                  s1_valid;
    logic                  s2_valid;
    logic                  s1_adv;
    logic                  s2_adv;
    logic                  accept;
    s1_t                   s1;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] sub_bytes;
    logic [DATA_WIDTH-1:0] added;
    logic [DATA_WIDTH-1:0] s2_next;

    assign s2_adv          = !s2_valid || round_ready_in;
    assign s1_adv          = !s1_valid || s2_adv;
    // Gated by reset so upstream sees no room while the pipeline is held clear.
    assign round_ready_out = rst && s1_adv;
    assign accept          = round_valid_in && round_ready_out;

    assign shifted = inv_shift_rows(state_in);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .value  (shifted[DATA_WIDTH-1-8*i -: 8]),
            .result (sub_bytes[DATA_WIDTH-1-8*i -: 8])
        );
    end

    always_comb begin
        added   = s1.data ^ s1.key;
        s2_next = s1.last ? added : inv_mix_columns(added);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1.data <= sub_bytes;
                s1.key  <= keyLen ? prev_key : key_in;
                s1.last <= last_round;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            state_out <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) state_out <= s2_next;
        end
    end

    assign round_valid_out = s2_valid;

endmodule

// File: tb/tb_decrypt_single_round.sv
// Scoreboard bench for decrypt_single_round against a byte-array AES inverse-round model
// whose inverse S-box is derived from GF(2^8) inversion and the forward affine map.
module tb_decrypt_single_round;

    logic         clk = 1'b0;
    logic         rst;
    logic         keyLen;
    logic         round_valid_in;
    logic         round_ready_out;
    logic         last_round;
    logic [127:0] state_in;
    logic [127:0] prev_key;
    logic [127:0] key_in;
    logic [127:0] state_out;
    logic         round_valid_out;
    logic         round_ready_in;

    int           tests  = 0;
    int           errors = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   inv_tbl[256];
    logic         held = 1'b0;
    logic [127:0] held_val;

    decrypt_single_round #(.DATA_WIDTH(128)) dut (
        .clk             (clk),
        .rst             (rst),
        .keyLen          (keyLen),
        .round_valid_in  (round_valid_in),
        .round_ready_out (round_ready_out),
        .last_round      (last_round),
        .state_in        (state_in),
        .prev_key        (prev_key),
        .key_in          (key_in),
        .state_out       (state_out),
        .round_valid_out (round_valid_out),
        .round_ready_in  (round_ready_in)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_table();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
        logic [7:0] a[16];
        logic [7:0] b[16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                b[row+4*c] = inv_tbl[a[row+4*((c+4-row)%4)]];
        for (int i = 0; i < 16; i++) b[i] = b[i] ^ key[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                a[row+4*c] = last ? b[row+4*c] :
                    ref_mul(8'h0e, b[row+4*c])         ^ ref_mul(8'h0b, b[(row+1)%4+4*c]) ^
                    ref_mul(8'h0d, b[(row+2)%4+4*c])   ^ ref_mul(8'h09, b[(row+3)%4+4*c]);
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops an expectation on each completed transfer and checks hold during stalls.
    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else if (round_valid_out) begin
            if (held) check("stall_hold", state_out, held_val);
            if (round_ready_in) begin
                held = 1'b0;
                tests++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: actual=%h required=none", state_out);
                end else begin
                    automatic logic [127:0] e = exp_q.pop_front();
                    if (state_out !== e) begin
                        errors++;
                        $display("FAIL output: actual=%h required=%h", state_out, e);
                    end
                end
            end else begin
                held     = 1'b1;
                held_val = state_out;
            end
        end else if (held) begin
            held = 1'b0;
            check("valid_dropped", 128'(round_valid_out), 128'd1);
        end
    end

    task automatic send(input logic [127:0] st, input logic kl, input logic [127:0] pk,
                        input logic [127:0] ki, input logic lr, input logic [127:0] exp);
        bit done = 1'b0;
        state_in = st; keyLen = kl; prev_key = pk; key_in = ki; last_round = lr;
        round_valid_in = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (round_ready_out) begin
                exp_q.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        round_valid_in = 1'b0;
        check("accept", 128'(done), 128'd1);
    endtask

    task automatic drain();
        round_ready_in = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] st, k, pk;
        logic         kl, lr;
        bit           rnd_done;

        rst = 1'b0; keyLen = 1'b0; round_valid_in = 1'b0; last_round = 1'b0;
        state_in = '0; prev_key = '0; key_in = '0; round_ready_in = 1'b1;
        build_table();
        #3;
        check("reset_valid_out", 128'(round_valid_out), 128'd0);
        check("reset_ready_out", 128'(round_ready_out), 128'd0);
        check("reset_state_out", state_out, 128'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("ready_after_reset", 128'(round_ready_out), 128'd1);

        // FIPS-197 C.1 middle round plus latency
        send(128'h7ad5fda789ef4e272bca100b3d9ff59f, 1'b0, '0,
             128'h549932d1f08557681093ed9cbe2c974e, 1'b0, 128'h54d990a16ba09ab596bbf40ea111702f);
        @(negedge clk) check("latency_cycle1_valid", 128'(round_valid_out), 128'd0);
        @(posedge clk); #1;
        @(negedge clk) check("latency_cycle2_valid", 128'(round_valid_out), 128'd1);
        @(posedge clk); #1;

        // Last round, keyLen=1 selects prev_key
        send(128'h7a9f102789d5f50b2beffd9f3dca4ea7, 1'b0, rnd128(), '0, 1'b0,
             ref_round(128'h7a9f102789d5f50b2beffd9f3dca4ea7, '0, 1'b0));
        send(128'h6353e08c0960e104cd70b751bacad0e7, 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
             rnd128(), 1'b1, 128'h00112233445566778899aabbccddeeff);

        // Key capture: key inputs change after acceptance
        st = rnd128(); k = rnd128();
        send(st, 1'b0, rnd128(), k, 1'b0, ref_round(st, k, 1'b0));
        @(posedge clk); #1;
        key_in = ~k; keyLen = 1'b1; prev_key = rnd128();
        drain();

        // Backpressure: two accepts fill the pipe, third waits for ready
        round_ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st = rnd128(); k = rnd128();
            send(st, 1'b0, '0, k, 1'b0, ref_round(st, k, 1'b0));
        end
        @(negedge clk) check("ready_low_when_full", 128'(round_ready_out), 128'd0);
        @(posedge clk); #1;
        st = rnd128(); k = rnd128();
        fork
            send(st, 1'b0, '0, k, 1'b0, ref_round(st, k, 1'b0));
            begin
                repeat (3) @(posedge clk);
                #1 round_ready_in = 1'b1;
            end
        join
        drain();

        // Reset with both stages full
        round_ready_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st = rnd128();
            send(st, 1'b0, '0, '0, 1'b0, ref_round(st, '0, 1'b0));
        end
        rst = 1'b0;
        #1;
        check("midreset_valid_out", 128'(round_valid_out), 128'd0);
        check("midreset_state_out", state_out, 128'd0);
        check("midreset_ready_out", 128'(round_ready_out), 128'd0);
        exp_q.delete();
        round_ready_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check("ready_after_midreset", 128'(round_ready_out), 128'd1);
        repeat (5) @(posedge clk);
        #1;

        // Random blocks with random downstream backpressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    st = rnd128(); k = rnd128(); pk = rnd128();
                    kl = 1'($urandom); lr = 1'($urandom);
                    send(st, kl, pk, k, lr, ref_round(st, kl ? pk : k, lr));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    round_ready_in = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
